// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_UP    = 2'd0,
        MODE_ROT_DOWN  = 2'd1,
        MODE_PING_PONG = 2'd2,
        MODE_BLINK     = 2'd3
    } led_mode_e;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
    localparam logic PHASE_ON  = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: pulses tick once every TICK_DIV enabled cycles; clr restarts the count.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: advances a rotate/ping-pong/blink pattern on each prescaler tick
// and drives the pins through a registered polarity stage.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int unsigned LED_NUM    = 3,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    output logic [LED_NUM-1:0] led,
    output logic               step_tick
);

    localparam int unsigned PW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(LED_NUM - 1);
    localparam logic [LED_NUM-1:0] ONE_HOT = LED_NUM'(1);
    localparam logic [LED_NUM-1:0] LED_RESET = ACTIVE_LOW ? ~ONE_HOT : ONE_HOT;

    logic [1:0]         mode_q;
    logic [PW-1:0]      pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               phase_q, phase_d;
    logic               step_tick_q, step_tick_d;
    logic [LED_NUM-1:0] led_q, led_d;
    logic [LED_NUM-1:0] on_d;
    logic               restart;
    logic               tick;

    assign restart = (mode != mode_q);

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (restart),
        .tick (tick)
    );

    always_comb begin
        pos_d       = pos_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        step_tick_d = 1'b0;
        // A mode change drops any coincident step and restarts from the new mode's origin.
        if (restart) begin
            pos_d   = (mode == MODE_ROT_DOWN) ? POS_LAST : '0;
            dir_d   = DIR_UP;
            phase_d = PHASE_ON;
        end else if (tick) begin
            step_tick_d = 1'b1;
            unique case (mode_q)
                MODE_ROT_UP:   pos_d = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
                MODE_ROT_DOWN: pos_d = (pos_q == '0) ? POS_LAST : pos_q - 1'b1;
                MODE_PING_PONG: begin
                    if (LED_NUM == 1) begin
                        pos_d = '0;
                    end else if (dir_q == DIR_UP) begin
                        if (pos_q == POS_LAST) begin
                            dir_d = DIR_DOWN;
                            pos_d = POS_LAST - 1'b1;
                        end else begin
                            pos_d = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_d = DIR_UP;
                            pos_d = PW'(1);
                        end else begin
                            pos_d = pos_q - 1'b1;
                        end
                    end
                end
                MODE_BLINK:    phase_d = ~phase_q;
            endcase
            if (pos_q > POS_LAST) begin
                pos_d = '0;
            end
        end

        if (mode == MODE_BLINK) begin
            on_d = {LED_NUM{phase_d}};
        end else begin
            on_d = ONE_HOT << pos_d;
        end
        led_d = ACTIVE_LOW ? ~on_d : on_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= mode;
            pos_q       <= '0;
            dir_q       <= DIR_UP;
            phase_q     <= PHASE_ON;
            step_tick_q <= 1'b0;
            led_q       <= LED_RESET;
        end else begin
            mode_q      <= mode;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            step_tick_q <= step_tick_d;
            led_q       <= led_d;
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;

endmodule
